regfile_host_ctrl: RTL and testbench

Byte-command sequencer between the host byte link (UART/SPI deserializer) and the 25-byte configuration register file. It parses write and read commands from a valid/ready byte stream and drives the register file's write and read strobes. It returns one response byte per command: ACK, NAK or read data. Partial commands are abandoned by a per-byte timeout.

---
 rtl/regfile_host_ctrl.sv | 173 +++++++++++++++++
 tb/tb_regfile_host_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_host_ctrl.sv
// Host byte-command sequencer for the configuration register file.
// Parses 'W' addr data / 'R' addr commands and answers each with one response byte.
module regfile_host_ctrl #(
    parameter int          FILE_SIZE_BYTES = 25,
    parameter int          TIMEOUT_CYCLES  = 100000,
    parameter logic [7:0]  ACK_BYTE        = 8'hAA,
    parameter logic [7:0]  NAK_BYTE        = 8'hEE
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_cmd_byte,
    input  logic       i_cmd_valid,
    output logic       o_cmd_ready,
    output logic [7:0] o_resp_byte,
    output logic       o_resp_valid,
    input  logic       i_resp_ready,
    output logic       o_rf_write,
    output logic [7:0] o_rf_wr_addr,
    output logic [7:0] o_rf_wr_byte,
    output logic       o_rf_read,
    output logic [7:0] o_rf_rd_addr,
    input  logic [7:0] i_rf_rd_byte,
    output logic       o_timeout
);

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [8:0] ADDR_LIM = 9'(FILE_SIZE_BYTES);
    localparam int         CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_ADDR,
        S_GET_DATA,
        S_WRITE,
        S_READ,
        S_READ_CAP,
        S_RESP
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic             op_w;
    logic             bad;
    logic [7:0]       addr;
    logic [7:0]       data;
    logic [7:0]       resp;
    logic [CNT_W-1:0] tmo_cnt;

    logic busy;
    logic ready_int;
    logic cmd_acc;
    logic byte_bad;
    logic is_opcode;
    logic tmo_hit;

    assign busy      = (state == S_GET_ADDR) || (state == S_GET_DATA);
    assign ready_int = (state == S_IDLE) || busy;
    assign cmd_acc   = i_cmd_valid && ready_int;
    assign byte_bad  = ({1'b0, i_cmd_byte} >= ADDR_LIM);
    assign is_opcode = (i_cmd_byte == OP_WRITE) || (i_cmd_byte == OP_READ);
    // An accepted byte in the terminal count cycle beats the timeout.
    assign tmo_hit   = busy && !cmd_acc && (tmo_cnt == CNT_MAX);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (cmd_acc) begin
                    state_nx = is_opcode ? S_GET_ADDR : S_RESP;
                end
            end
            S_GET_ADDR: begin
                if (cmd_acc) begin
                    if (op_w) begin
                        state_nx = S_GET_DATA;
                    end else begin
                        state_nx = byte_bad ? S_RESP : S_READ;
                    end
                end else if (tmo_hit) begin
                    state_nx = S_IDLE;
                end
            end
            S_GET_DATA: begin
                if (cmd_acc) begin
                    state_nx = bad ? S_RESP : S_WRITE;
                end else if (tmo_hit) begin
                    state_nx = S_IDLE;
                end
            end
            S_WRITE:    state_nx = S_RESP;
            S_READ:     state_nx = S_READ_CAP;
            S_READ_CAP: state_nx = S_RESP;
            S_RESP: begin
                if (i_resp_ready) begin
                    state_nx = S_IDLE;
                end
            end
            default:    state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        o_cmd_ready  = ready_int;
        o_rf_write   = (state == S_WRITE);
        o_rf_read    = (state == S_READ);
        o_resp_valid = (state == S_RESP);
        o_timeout    = tmo_hit;
        o_resp_byte  = resp;
        o_rf_wr_addr = addr;
        o_rf_wr_byte = data;
        o_rf_rd_addr = addr;
    end

    // Command fields, response byte and inter-byte idle counter.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            op_w    <= 1'b0;
            bad     <= 1'b0;
            addr    <= 8'h00;
            data    <= 8'h00;
            resp    <= 8'h00;
            tmo_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_acc) begin
                        op_w <= (i_cmd_byte == OP_WRITE);
                        if (!is_opcode) begin
                            resp <= NAK_BYTE;
                        end
                    end
                end
                S_GET_ADDR: begin
                    if (cmd_acc) begin
                        addr <= i_cmd_byte;
                        bad  <= byte_bad;
                        if (!op_w && byte_bad) begin
                            resp <= NAK_BYTE;
                        end
                    end
                end
                S_GET_DATA: begin
                    if (cmd_acc) begin
                        data <= i_cmd_byte;
                        if (bad) begin
                            resp <= NAK_BYTE;
                        end
                    end
                end
                S_WRITE:    resp <= ACK_BYTE;
                S_READ_CAP: resp <= i_rf_rd_byte;
                default: ;
            endcase

            if (!busy || cmd_acc) begin
                tmo_cnt <= '0;
            end else if (tmo_cnt != CNT_MAX) begin
                tmo_cnt <= tmo_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_regfile_host_ctrl.sv
// Scoreboard bench for regfile_host_ctrl with a behavioural register file
// and a short timeout so idle-abandon cases run quickly.
module tb_regfile_host_ctrl;

    logic       i_clk;
    logic       i_rst;
    logic [7:0] i_cmd_byte;
    logic       i_cmd_valid;
    logic       o_cmd_ready;
    logic [7:0] o_resp_byte;
    logic       o_resp_valid;
    logic       i_resp_ready;
    logic       o_rf_write;
    logic [7:0] o_rf_wr_addr;
    logic [7:0] o_rf_wr_byte;
    logic       o_rf_read;
    logic [7:0] o_rf_rd_addr;
    logic [7:0] i_rf_rd_byte;
    logic       o_timeout;

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mem [256];

    int         wr_cnt = 0;
    int         rd_cnt = 0;
    int         to_cnt = 0;
    logic [7:0] last_wr_addr = 8'h00;
    logic [7:0] last_wr_data = 8'h00;
    logic [7:0] last_rd_addr = 8'h00;

    regfile_host_ctrl #(
        .FILE_SIZE_BYTES(25),
        .TIMEOUT_CYCLES (8),
        .ACK_BYTE       (8'hAA),
        .NAK_BYTE       (8'hEE)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_cmd_byte   (i_cmd_byte),
        .i_cmd_valid  (i_cmd_valid),
        .o_cmd_ready  (o_cmd_ready),
        .o_resp_byte  (o_resp_byte),
        .o_resp_valid (o_resp_valid),
        .i_resp_ready (i_resp_ready),
        .o_rf_write   (o_rf_write),
        .o_rf_wr_addr (o_rf_wr_addr),
        .o_rf_wr_byte (o_rf_wr_byte),
        .o_rf_read    (o_rf_read),
        .o_rf_rd_addr (o_rf_rd_addr),
        .i_rf_rd_byte (i_rf_rd_byte),
        .o_timeout    (o_timeout)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Register file: write on strobe, read data registered one cycle later.
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        i_rf_rd_byte = 8'h00;
    end
    always @(posedge i_clk) begin
        if (o_rf_write) mem[o_rf_wr_addr] <= o_rf_wr_byte;
        if (o_rf_read)  i_rf_rd_byte <= mem[o_rf_rd_addr];
    end

    always @(negedge i_clk) begin
        if (!i_rst) begin
            if (o_rf_write) begin
                wr_cnt++;
                last_wr_addr = o_rf_wr_addr;
                last_wr_data = o_rf_wr_byte;
            end
            if (o_rf_read) begin
                rd_cnt++;
                last_rd_addr = o_rf_rd_addr;
            end
            if (o_rf_write || o_rf_read)
                check("strobe_excl", {31'd0, o_rf_write & o_rf_read}, 32'd0);
            if (o_timeout) to_cnt++;
            if (o_resp_valid && i_resp_ready) begin
                check("resp_pending", {31'd0, exp_q.size() > 0}, 32'd1);
                if (exp_q.size() > 0) check("resp_byte", {24'd0, o_resp_byte}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        @(negedge i_clk);
        i_cmd_byte  = b;
        i_cmd_valid = 1'b1;
        n = 0;
        while (!o_cmd_ready && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        if (!o_cmd_ready) check("send_timeout", {31'd0, o_cmd_ready}, 32'd1);
        @(posedge i_clk);
        #1 i_cmd_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        check("drain", exp_q.size(), 32'd0);
        @(negedge i_clk);
    endtask

    initial begin
        int w0, r0;
        i_rst        = 1'b1;
        i_cmd_byte   = 8'h00;
        i_cmd_valid  = 1'b0;
        i_resp_ready = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        check("rst_ready",  {31'd0, o_cmd_ready},  32'd1);
        check("rst_rvalid", {31'd0, o_resp_valid}, 32'd0);
        check("rst_rbyte",  {24'd0, o_resp_byte},  32'd0);
        check("rst_write",  {31'd0, o_rf_write},   32'd0);
        check("rst_read",   {31'd0, o_rf_read},    32'd0);
        check("rst_waddr",  {24'd0, o_rf_wr_addr}, 32'd0);
        check("rst_wdata",  {24'd0, o_rf_wr_byte}, 32'd0);
        check("rst_raddr",  {24'd0, o_rf_rd_addr}, 32'd0);
        check("rst_tmo",    {31'd0, o_timeout},    32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;

        // Write then read back
        w0 = wr_cnt;
        exp_q.push_back(8'hAA);
        send_byte(8'h57); send_byte(8'h05); send_byte(8'h3C);
        wait_drain();
        check("wr_count", wr_cnt - w0, 32'd1);
        check("wr_addr", {24'd0, last_wr_addr}, 32'h05);
        check("wr_data", {24'd0, last_wr_data}, 32'h3C);
        r0 = rd_cnt;
        exp_q.push_back(8'h3C);
        send_byte(8'h52); send_byte(8'h05);
        wait_drain();
        check("rd_count", rd_cnt - r0, 32'd1);
        check("rd_addr", {24'd0, last_rd_addr}, 32'h05);

        // Highest valid address
        exp_q.push_back(8'hAA);
        send_byte(8'h57); send_byte(8'h18); send_byte(8'h77);
        exp_q.push_back(8'h77);
        send_byte(8'h52); send_byte(8'h18);
        wait_drain();

        // Out of range write and read
        w0 = wr_cnt;
        exp_q.push_back(8'hEE);
        send_byte(8'h57); send_byte(8'h19); send_byte(8'hFF);
        wait_drain();
        check("oor_no_write", wr_cnt - w0, 32'd0);
        check("oor_mem", {24'd0, mem[8'h19]}, 32'd0);
        r0 = rd_cnt;
        exp_q.push_back(8'hEE);
        send_byte(8'h52); send_byte(8'hFF);
        wait_drain();
        check("oor_no_read", rd_cnt - r0, 32'd0);

        // Bad opcode, next byte is a fresh opcode
        exp_q.push_back(8'hEE);
        send_byte(8'h41);
        check("nak_latency", {31'd0, o_resp_valid}, 32'd1);
        exp_q.push_back(8'h3C);
        send_byte(8'h52); send_byte(8'h05);
        wait_drain();

        // Response backpressure with a pending command byte
        i_resp_ready = 1'b0;
        exp_q.push_back(8'hAA);
        send_byte(8'h57); send_byte(8'h03); send_byte(8'h5A);
        r0 = rd_cnt;
        i_cmd_byte  = 8'h52;
        i_cmd_valid = 1'b1;
        repeat (2) @(negedge i_clk);
        for (int k = 0; k < 10; k++) begin
            @(negedge i_clk);
            check("bp_valid", {31'd0, o_resp_valid}, 32'd1);
            check("bp_byte",  {24'd0, o_resp_byte},  32'hAA);
            check("bp_ready", {31'd0, o_cmd_ready},  32'd0);
        end
        i_resp_ready = 1'b1;
        exp_q.push_back(8'h5A);
        send_byte(8'h52); send_byte(8'h03);
        wait_drain();
        check("bp_rd_count", rd_cnt - r0, 32'd1);

        // Timeout after an opcode with nothing following
        w0 = to_cnt;
        send_byte(8'h57);
        for (int k = 0; k < 8; k++) begin
            @(negedge i_clk);
            check($sformatf("tmo_cyc%0d", k), {31'd0, o_timeout}, (k == 7) ? 32'd1 : 32'd0);
            check("tmo_no_resp", {31'd0, o_resp_valid}, 32'd0);
        end
        @(negedge i_clk);
        check("tmo_pulses", to_cnt - w0, 32'd1);
        check("tmo_idle_ready", {31'd0, o_cmd_ready}, 32'd1);
        exp_q.push_back(8'h3C);
        send_byte(8'h52); send_byte(8'h05);
        wait_drain();

        // Byte in the terminal count cycle wins
        w0 = to_cnt;
        send_byte(8'h57);
        repeat (7) @(negedge i_clk);
        @(negedge i_clk);
        i_cmd_byte  = 8'h06;
        i_cmd_valid = 1'b1;
        #1 check("tmo_byte_wins", {31'd0, o_timeout}, 32'd0);
        @(posedge i_clk);
        #1 i_cmd_valid = 1'b0;
        exp_q.push_back(8'hAA);
        send_byte(8'h66);
        wait_drain();
        check("tmo_none", to_cnt - w0, 32'd0);
        check("late_wr_addr", {24'd0, last_wr_addr}, 32'h06);
        check("late_wr_data", {24'd0, last_wr_data}, 32'h66);

        // Async reset between address and data
        w0 = wr_cnt;
        send_byte(8'h57); send_byte(8'h07);
        #2 i_rst = 1'b1;
        #1;
        check("arst_ready",  {31'd0, o_cmd_ready},  32'd1);
        check("arst_write",  {31'd0, o_rf_write},   32'd0);
        check("arst_waddr",  {24'd0, o_rf_wr_addr}, 32'd0);
        check("arst_rvalid", {31'd0, o_resp_valid}, 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        repeat (3) @(negedge i_clk);
        check("arst_ready2", {31'd0, o_cmd_ready}, 32'd1);
        exp_q.push_back(8'h00);
        send_byte(8'h52); send_byte(8'h07);
        wait_drain();
        check("arst_no_write", wr_cnt - w0, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
